wb_arbiter: RTL and testbench

Write-back arbiter for the register file's single write port. Two producers compete for that port: the ALU pipe (single-cycle results) and the load/store unit (variable-latency load data). The block grants one per cycle with a valid/ready handshake, registers the winning write onto the register file write port, and reports which source registers still have a write queued upstream so the issue stage can stall.

---
 rtl/wb_arbiter_pkg.sv | 12 +
 rtl/rr_arbiter2.sv | 42 ++++
 rtl/wb_arbiter.sv | 83 ++++++++
 tb/tb_wb_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared write-back encodings: register file write enable levels and grant/pointer source indices.
package wb_arbiter_pkg;

   localparam logic REG_WRITE_ENABLE  = 1'b1;
   localparam logic REG_WRITE_DISABLE = 1'b0;
   localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

   // Bit positions in the request/grant vectors; also the round-robin pointer values.
   localparam logic WB_SRC_ALU = 1'b0;
   localparam logic WB_SRC_LSU = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; combinational one-hot grant, pointer advances on contested cycles only.
// No grant while reset is low; a forced request wins without moving the pointer.
module rr_arbiter2
   import wb_arbiter_pkg::*;
(
   input  logic       i_clock,
   input  logic       i_reset_n,
   input  logic [1:0] i_req,
   input  logic [1:0] i_force,
   output logic [1:0] o_grant
);

   logic ptr;
   logic contested;

   always_comb begin
      o_grant   = 2'b00;
      contested = 1'b0;
      if (!i_reset_n) begin
         o_grant = 2'b00;
      end else if (i_force[WB_SRC_LSU] && i_req[WB_SRC_LSU]) begin
         o_grant[WB_SRC_LSU] = 1'b1;
      end else if (i_force[WB_SRC_ALU] && i_req[WB_SRC_ALU]) begin
         o_grant[WB_SRC_ALU] = 1'b1;
      end else if (&i_req) begin
         contested    = 1'b1;
         o_grant[ptr] = 1'b1;
      end else begin
         o_grant = i_req;
      end
   end

   // Pointer names the source favoured on the next contest: the loser of this one.
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         ptr <= WB_SRC_ALU;
      end else if (contested) begin
         ptr <= ~ptr;
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: ALU vs LSU onto the single register file write port, 1-cycle registered write.
// Ready is combinational from valids and pointer; the write port never back-pressures.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5
)(
   input  logic               i_clock,
   input  logic               i_reset_n,
   input  logic               i_alu_valid,
   input  logic [RADDR_W-1:0] i_alu_rd,
   input  logic [XLEN-1:0]    i_alu_data,
   output logic               o_alu_ready,
   input  logic               i_lsu_valid,
   input  logic [RADDR_W-1:0] i_lsu_rd,
   input  logic [XLEN-1:0]    i_lsu_data,
   output logic               o_lsu_ready,
   output logic               o_readwrite,
   output logic [RADDR_W-1:0] o_writereg,
   output logic [XLEN-1:0]    o_writedata,
   input  logic [RADDR_W-1:0] i_query_rs1,
   input  logic [RADDR_W-1:0] i_query_rs2,
   output logic               o_rs1_pending,
   output logic               o_rs2_pending
);

   logic [1:0]         req;
   logic [1:0]         force_grant;
   logic [1:0]         grant;
   logic               same_rd;
   logic               accept;
   logic [RADDR_W-1:0] wb_rd;
   logic [XLEN-1:0]    wb_data;

   // LSU data is older in program order, so on a same-rd clash it must land first.
   assign same_rd = i_alu_valid && i_lsu_valid && (i_alu_rd == i_lsu_rd) && (i_lsu_rd != '0);

   always_comb begin
      req                     = 2'b00;
      req[WB_SRC_ALU]         = i_alu_valid;
      req[WB_SRC_LSU]         = i_lsu_valid;
      force_grant             = 2'b00;
      force_grant[WB_SRC_LSU] = same_rd;
   end

   rr_arbiter2 u_rr_arbiter2 (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .i_req     (req),
      .i_force   (force_grant),
      .o_grant   (grant)
   );

   assign o_alu_ready = grant[WB_SRC_ALU];
   assign o_lsu_ready = grant[WB_SRC_LSU];
   assign accept      = |grant;
   assign wb_rd       = grant[WB_SRC_LSU] ? i_lsu_rd   : i_alu_rd;
   assign wb_data     = grant[WB_SRC_LSU] ? i_lsu_data : i_alu_data;

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         o_readwrite <= REG_WRITE_DISABLE;
         o_writereg  <= '0;
         o_writedata <= '0;
      end else begin
         o_readwrite <= (accept && (wb_rd != '0)) ? REG_WRITE_ENABLE : REG_WRITE_DISABLE;
         if (accept) begin
            o_writereg  <= wb_rd;
            o_writedata <= wb_data;
         end
      end
   end

   // The register on the write port is bypassed by the register file, so only upstream holders count.
   assign o_rs1_pending = (i_query_rs1 != '0) &&
                          ((i_alu_valid && (i_alu_rd == i_query_rs1)) ||
                           (i_lsu_valid && (i_lsu_rd == i_query_rs1)));
   assign o_rs2_pending = (i_query_rs2 != '0) &&
                          ((i_alu_valid && (i_alu_rd == i_query_rs2)) ||
                           (i_lsu_valid && (i_lsu_rd == i_query_rs2)));

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with a small register file model fed from the write port.
module tb_wb_arbiter;

   logic        i_clock;
   logic        i_reset_n;
   logic        i_alu_valid;
   logic [4:0]  i_alu_rd;
   logic [31:0] i_alu_data;
   logic        o_alu_ready;
   logic        i_lsu_valid;
   logic [4:0]  i_lsu_rd;
   logic [31:0] i_lsu_data;
   logic        o_lsu_ready;
   logic        o_readwrite;
   logic [4:0]  o_writereg;
   logic [31:0] o_writedata;
   logic [4:0]  i_query_rs1;
   logic [4:0]  i_query_rs2;
   logic        o_rs1_pending;
   logic        o_rs2_pending;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] rf [32];

   wb_arbiter #(.XLEN(32), .RADDR_W(5)) dut (
      .i_clock       (i_clock),
      .i_reset_n     (i_reset_n),
      .i_alu_valid   (i_alu_valid),
      .i_alu_rd      (i_alu_rd),
      .i_alu_data    (i_alu_data),
      .o_alu_ready   (o_alu_ready),
      .i_lsu_valid   (i_lsu_valid),
      .i_lsu_rd      (i_lsu_rd),
      .i_lsu_data    (i_lsu_data),
      .o_lsu_ready   (o_lsu_ready),
      .o_readwrite   (o_readwrite),
      .o_writereg    (o_writereg),
      .o_writedata   (o_writedata),
      .i_query_rs1   (i_query_rs1),
      .i_query_rs2   (i_query_rs2),
      .o_rs1_pending (o_rs1_pending),
      .o_rs2_pending (o_rs2_pending)
   );

   initial i_clock = 1'b0;
   always #5 i_clock = ~i_clock;

   always @(posedge i_clock) begin
      if (o_readwrite) rf[o_writereg] <= o_writedata;
   end

   function automatic logic [31:0] rf_read(input logic [4:0] idx);
      if (o_readwrite && (o_writereg == idx)) return o_writedata;
      return rf[idx];
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
      i_alu_valid = av;  i_alu_rd = ard;  i_alu_data = adat;
      i_lsu_valid = lv;  i_lsu_rd = lrd;  i_lsu_data = ldat;
      #1;
   endtask

   task automatic tick();
      @(posedge i_clock);
      #1;
   endtask

   task automatic check_port(input string tag, input logic rw, input logic [4:0] rd, input logic [31:0] dat);
      check({tag, "_rw"},   {63'd0, o_readwrite}, {63'd0, rw});
      check({tag, "_reg"},  {59'd0, o_writereg},  {59'd0, rd});
      check({tag, "_data"}, {32'd0, o_writedata}, {32'd0, dat});
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'h0;
      i_reset_n   = 1'b0;
      i_query_rs1 = 5'd0;
      i_query_rs2 = 5'd0;

      // Reset with both sources offering
      drive(1'b1, 5'd1, 32'h1111_1111, 1'b1, 5'd2, 32'h2222_2222);
      tick();
      tick();
      check("rst_alu_rdy", {63'd0, o_alu_ready}, 64'd0);
      check("rst_lsu_rdy", {63'd0, o_lsu_ready}, 64'd0);
      check_port("rst", 1'b0, 5'd0, 32'h0);

      // Release: ALU favoured on the first contest, pointer moves to LSU
      i_reset_n = 1'b1;
      #1;
      check("rel_alu_rdy", {63'd0, o_alu_ready}, 64'd1);
      check("rel_lsu_rdy", {63'd0, o_lsu_ready}, 64'd0);
      tick();
      check_port("rel", 1'b1, 5'd1, 32'h1111_1111);

      // Single source
      drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0);
      check("ss_alu_rdy", {63'd0, o_alu_ready}, 64'd1);
      check("ss_lsu_rdy", {63'd0, o_lsu_ready}, 64'd0);
      tick();
      check_port("ss", 1'b1, 5'd5, 32'hDEAD_BEEF);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      check("ss_bypass_x5", {32'd0, rf_read(5'd5)}, {32'd0, 32'hDEAD_BEEF});
      tick();
      check_port("ss_idle", 1'b0, 5'd5, 32'hDEAD_BEEF);
      check("ss_rf_x5", {32'd0, rf_read(5'd5)}, {32'd0, 32'hDEAD_BEEF});

      // Round-robin: pointer favours LSU after the release contest
      for (int i = 0; i < 4; i++) begin
         logic lsu_turn;
         lsu_turn = (i % 2 == 0);
         drive(1'b1, 5'd3, 32'hAAAA_0003, 1'b1, 5'd4, 32'hBBBB_0004);
         check($sformatf("rr%0d_alu_rdy", i), {63'd0, o_alu_ready}, {63'd0, !lsu_turn});
         check($sformatf("rr%0d_lsu_rdy", i), {63'd0, o_lsu_ready}, {63'd0, lsu_turn});
         tick();
         if (lsu_turn) check_port($sformatf("rr%0d", i), 1'b1, 5'd4, 32'hBBBB_0004);
         else          check_port($sformatf("rr%0d", i), 1'b1, 5'd3, 32'hAAAA_0003);
      end

      // Same-rd conflict: LSU first, ALU value persists
      drive(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2);
      check("srd_lsu_rdy", {63'd0, o_lsu_ready}, 64'd1);
      check("srd_alu_rdy", {63'd0, o_alu_ready}, 64'd0);
      tick();
      check_port("srd_w1", 1'b1, 5'd7, 32'h2);
      drive(1'b1, 5'd7, 32'h1, 1'b0, 5'd0, 32'h0);
      check("srd_alu_rdy2", {63'd0, o_alu_ready}, 64'd1);
      tick();
      check_port("srd_w2", 1'b1, 5'd7, 32'h1);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      tick();
      check("srd_rf_x7", {32'd0, rf[7]}, {32'd0, 32'h1});

      // x0 and pending: pointer favours LSU, so the ALU stalls one cycle
      i_query_rs1 = 5'd9;
      i_query_rs2 = 5'd0;
      drive(1'b1, 5'd9, 32'h0000_0099, 1'b1, 5'd0, 32'h0000_FFFF);
      check("x0_lsu_rdy", {63'd0, o_lsu_ready}, 64'd1);
      check("x0_alu_rdy", {63'd0, o_alu_ready}, 64'd0);
      check("x0_rs1_pend", {63'd0, o_rs1_pending}, 64'd1);
      check("x0_rs2_pend", {63'd0, o_rs2_pending}, 64'd0);
      tick();
      check("x0_rw", {63'd0, o_readwrite}, 64'd0);
      drive(1'b1, 5'd9, 32'h0000_0099, 1'b0, 5'd0, 32'h0);
      check("x0_alu_rdy2", {63'd0, o_alu_ready}, 64'd1);
      check("x0_rs1_pend2", {63'd0, o_rs1_pending}, 64'd1);
      check("x0_rs2_pend2", {63'd0, o_rs2_pending}, 64'd0);
      tick();
      check_port("x0_w9", 1'b1, 5'd9, 32'h0000_0099);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      check("x0_rs1_pend3", {63'd0, o_rs1_pending}, 64'd0);
      check("x0_rs2_pend3", {63'd0, o_rs2_pending}, 64'd0);
      tick();
      check("x0_rf_x0", {32'd0, rf[0]}, 64'd0);

      // Reset the cycle after an ALU handshake
      drive(1'b1, 5'd12, 32'h1234_5678, 1'b0, 5'd0, 32'h0);
      check("mr_alu_rdy", {63'd0, o_alu_ready}, 64'd1);
      tick();
      i_reset_n = 1'b0;
      drive(1'b1, 5'd13, 32'h0BAD_0BAD, 1'b0, 5'd0, 32'h0);
      check("mr_alu_rdy_rst", {63'd0, o_alu_ready}, 64'd0);
      tick();
      check_port("mr_rst", 1'b0, 5'd0, 32'h0);
      tick();
      check_port("mr_rst2", 1'b0, 5'd0, 32'h0);
      check("mr_rf_x13", {32'd0, rf[13]}, 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
